// File: rtl/mem_responder.sv
// mem_responder: word-wide memory target with a registered request/response
// handshake and LATENCY wait states (IDLE -> WAIT -> DONE -> IDLE).
// Optional feature macro: MEM_ADDR_CHECK_EN
//   defined   : misaligned or out-of-range addresses answer with resp_err=1
//   undefined : addr[1:0] ignored, index wraps modulo DEPTH
module mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          busy
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          lat_rd_q, lat_rd_d;
    logic          lat_wr_q, lat_wr_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [31:0]   lat_wdata_q, lat_wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   mem_q [DEPTH];

    // Access operands: live inputs when the access happens on the acceptance
    // edge (LATENCY=0), latched request otherwise.
    logic          acc_rd, acc_wr, acc_err;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [IW-1:0] acc_idx;
    logic          enter_done;
    logic          mem_we;

    // Select access operands and classify the request as erroneous or not
    always_comb begin
        if (state_q == IDLE) begin
            acc_rd    = req_rd;
            acc_wr    = req_wr;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_rd    = lat_rd_q;
            acc_wr    = lat_wr_q;
            acc_addr  = lat_addr_q;
            acc_wdata = lat_wdata_q;
        end
        acc_idx = acc_addr[IW+1:2];
`ifdef MEM_ADDR_CHECK_EN
        acc_err = (acc_rd & acc_wr)
                | (acc_addr[1:0] != 2'b00)
                | ((acc_addr >> (IW + 2)) != '0);
`else
        acc_err = acc_rd & acc_wr;
`endif
    end

`ifndef MEM_ADDR_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[AW-1:IW+2], acc_addr[1:0]};
`endif

    // Next-state, request latching, response formation and memory write enable
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        lat_rd_d     = lat_rd_q;
        lat_wr_d     = lat_wr_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        enter_done   = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_rd | req_wr) begin
                    lat_rd_d    = req_rd;
                    lat_wr_d    = req_wr;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    wait_cnt_d  = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_done) begin
            resp_err_d   = acc_err;
            resp_rdata_d = (acc_rd && !acc_err) ? mem_q[acc_idx] : '0;
            // Reset on the commit edge must drop the write as well.
            mem_we       = acc_wr & ~acc_err & ~rst;
        end

        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == DONE);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            lat_rd_q     <= 1'b0;
            lat_wr_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            lat_rd_q     <= lat_rd_d;
            lat_wr_q     <= lat_wr_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage array; contents are untouched by reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios plus randomized traffic for
// mem_responder, checked every cycle against a transaction-timeline model.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    mem_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(LAT),
        .AW     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: an accepted request completes LAT edges after acceptance,
    // the target is unavailable until one edge after that.
    logic [31:0] mmem [DEPTH];
    bit          inflight = 1'b0;
    int          age = 0;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wdata;
    logic        m_ready = 1'b1;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
    end

    task automatic model_access();
        bit err;
        int idx;
        err = p_rd && p_wr;
`ifdef MEM_ADDR_CHECK_EN
        if (p_addr % 4 != 0) err = 1;
        if (p_addr >= 4 * DEPTH) err = 1;
`endif
        idx = int'((p_addr / 4) % DEPTH);
        m_err   = err;
        m_rdata = '0;
        if (!err && p_wr) mmem[idx] = p_wdata;
        if (!err && p_rd) m_rdata = mmem[idx];
    endtask

    always @(posedge clk) begin
        if (rst) begin
            inflight = 0;
            m_ready  = 1;
            m_valid  = 0;
            m_rdata  = '0;
            m_err    = 0;
        end else begin
            if (!inflight && (req_rd || req_wr)) begin
                inflight = 1;
                age      = -1;
                p_rd     = req_rd;
                p_wr     = req_wr;
                p_addr   = req_addr;
                p_wdata  = req_wdata;
            end
            if (inflight) begin
                age++;
                if (age == int'(LAT)) begin
                    model_access();
                    m_valid = 1;
                    m_ready = 0;
                end else if (age == int'(LAT) + 1) begin
                    inflight = 0;
                    m_valid  = 0;
                    m_ready  = 1;
                end else begin
                    m_valid = 0;
                    m_ready = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  32'(req_ready),  32'(m_ready));
            check("busy",       32'(busy),       32'(!m_ready));
            check("resp_valid", 32'(resp_valid), 32'(m_valid));
            check("resp_rdata", resp_rdata,      m_rdata);
            check("resp_err",   32'(resp_err),   32'(m_err));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            if (m_ready) return;
            @(negedge clk);
        end
        n_cmp++;
        n_mis++;
        $display("FAIL wait_ready: got timeout expected ready within 50 cycles");
    endtask

    // Called at a negedge; n=1 means resp_valid is high in the current cycle.
    task automatic wait_valid(output int n, output logic [31:0] rdata, output logic e);
        n = 0;
        rdata = '0;
        e = 1'b0;
        for (int i = 0; i < 50; i++) begin
            n++;
            if (resp_valid) begin
                rdata = resp_rdata;
                e = resp_err;
                return;
            end
            @(negedge clk);
        end
        n_cmp++;
        n_mis++;
        $display("FAIL wait_valid: got timeout expected resp_valid within 50 cycles");
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output int n, output logic [31:0] rdata, output logic e);
        wait_ready();
        req_rd = rd;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0;
        req_wr = 1'b0;
        wait_valid(n, rdata, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n, n2, vcount;
        logic [31:0] rd_v;
        logic        e_v;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        repeat (5) begin
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'd1);
            check("idle_valid", 32'(resp_valid), 32'd0);
            check("idle_rdata", resp_rdata, 32'd0);
            check("idle_err",   32'(resp_err), 32'd0);
        end

        // Write then read back
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, n, rd_v, e_v);
        check("wr_latency", 32'(n), 32'd3);
        check("wr_err", 32'(e_v), 32'd0);
        check("wr_rdata", rd_v, 32'd0);
        @(negedge clk);
        check("rd_ready_T4", 32'(req_ready), 32'd1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, n, rd_v, e_v);
        check("rd_latency", 32'(n), 32'd3);
        check("rd_data", rd_v, 32'hDEADBEEF);

        // Simultaneous rd+wr is rejected and leaves memory alone
        issue(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, n, rd_v, e_v);
        issue(1'b1, 1'b1, 32'h20, 32'h0BADBAD0, n, rd_v, e_v);
        check("both_err", 32'(e_v), 32'd1);
        check("both_rdata", rd_v, 32'd0);
        issue(1'b1, 1'b0, 32'h20, 32'h0, n, rd_v, e_v);
        check("both_keep", rd_v, 32'hCAFEF00D);

        // Request held through WAIT/DONE with changed address
        issue(1'b0, 1'b1, 32'h40, 32'h11111111, n, rd_v, e_v);
        issue(1'b0, 1'b1, 32'h44, 32'h22222222, n, rd_v, e_v);
        wait_ready();
        req_rd = 1'b1;
        req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h44;
        wait_valid(n, rd_v, e_v);
        check("hold_first_lat", 32'(n), 32'd3);
        check("hold_first_data", rd_v, 32'h11111111);
        @(negedge clk);
        wait_valid(n2, rd_v, e_v);
        req_rd = 1'b0;
        check("hold_second_gap", 32'(n2), 32'd4);
        check("hold_second_data", rd_v, 32'h22222222);

        // Out-of-range, misaligned read
        issue(1'b0, 1'b1, 32'h0, 32'h5A5A5A5A, n, rd_v, e_v);
        issue(1'b1, 1'b0, 32'h401, 32'h0, n, rd_v, e_v);
`ifdef MEM_ADDR_CHECK_EN
        check("oor_err", 32'(e_v), 32'd1);
        check("oor_rdata", rd_v, 32'd0);
`else
        check("wrap_err", 32'(e_v), 32'd0);
        check("wrap_rdata", rd_v, 32'h5A5A5A5A);
`endif

        // Reset while a write is waiting
        @(negedge clk);
        wait_ready();
        req_wr = 1'b1;
        req_addr = 32'h8;
        req_wdata = 32'h1234;
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b0;
        rst = 1'b1;
        vcount = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            if (resp_valid) vcount++;
            @(negedge clk);
        end
        check("rst_no_resp", 32'(vcount), 32'd0);
        issue(1'b1, 1'b0, 32'h8, 32'h0, n, rd_v, e_v);
        check("rst_dropped_write", rd_v, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) begin
                sel = int'($urandom_range(0, 11));
                req_rd = (sel >= 4 && sel <= 7) || sel == 11;
                req_wr = (sel >= 8);
                case ($urandom_range(0, 7))
                    0:       req_addr = 32'h400 + 4 * $urandom_range(0, 3);
                    1:       req_addr = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
                    2:       req_addr = $urandom;
                    default: req_addr = 4 * $urandom_range(0, 15);
                endcase
                req_wdata = $urandom;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        req_rd = 1'b0;
        req_wr = 1'b0;
        repeat (10) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-wide memory target that answers the multicycle CPU's instruction and data memory accesses. It uses a registered request/response handshake with a programmable number of wait states. It replaces the zero-latency combinational memory model so the controller FSM can be exercised against realistic latency. It sits between the CPU's address mux (PC or ALUOut), its B-register write-data path, and the IR/MDR load path.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 4
- LATENCY, 2, wait-state cycles between acceptance and response; 0..15
- AW, 32, request address width (byte address)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- req_rd  in  1  read request (MemRd)
- req_wr  in  1  write request (MemWr)
- req_addr  in  AW  byte address
- req_wdata  in  32  write data
- req_ready  out  1  high when a request can be accepted
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data; valid with resp_valid
- resp_err  out  1  request rejected; valid with resp_valid
- busy  out  1  request in flight; equals ~req_ready

## Operation
- States: IDLE, WAIT, DONE. All outputs are registered from state and latches.
- IDLE: req_ready=1. If (req_rd|req_wr) is high, the request is accepted: rd, wr, addr, and wdata are latched and wait_cnt=LATENCY is loaded. The FSM goes to WAIT, or straight to DONE if LATENCY=0.
- WAIT: wait_cnt decrements each cycle. When wait_cnt==1, the FSM goes to DONE; the memory access is performed on that same edge.
- DONE: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE. Requests presented in WAIT or DONE are ignored and not queued. The initiator must hold them until req_ready=1.
- Write: mem[idx] <= wdata is committed on the edge entering DONE. resp_rdata=0.
- Read: resp_rdata = mem[idx], sampled on the edge entering DONE.
- idx = addr[log2(DEPTH)+1:2].
- req_rd and req_wr both high: resp_err=1, no memory access, resp_rdata=0.
- Errors never block the FSM. Every accepted request yields exactly one resp_valid.
- Reset values: state=IDLE, req_ready=1, busy=0, resp_valid=0, resp_rdata=0, resp_err=0, wait_cnt=0.
- Memory contents are not affected by rst and are zero at time 0.
- Reset mid-operation drops the pending request. A write not yet committed (FSM not yet in DONE) is never committed, and no response is produced.

## Timing
- Request accepted in cycle T (req_ready=1 and a request present at the rising edge ending T).
- resp_valid is high in cycle T+LATENCY+1. req_ready returns high in cycle T+LATENCY+2.
- Throughput is one access per LATENCY+2 cycles. Back-to-back requests held high are accepted in the first IDLE cycle.
- resp_rdata and resp_err hold their value after resp_valid falls, until the next DONE or reset.
- LATENCY=0: the response arrives in cycle T+1.
- Read-after-write to the same word returns the new data, because the write commits before the next acceptance.

## Configuration
- MEM_ADDR_CHECK_EN defined:
  - addr[1:0]≠0 (misaligned) raises resp_err=1 with no access.
  - addr ≥ 4*DEPTH (out of range) raises resp_err=1 with no access.
  - In both cases resp_rdata=0.
- MEM_ADDR_CHECK_EN undefined:
  - addr[1:0] is ignored and the upper address bits are truncated, so the index wraps modulo DEPTH.
  - resp_err is raised only for simultaneous rd+wr.

## Test plan
- Reset, then idle 5 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 throughout.
- LATENCY=2: write 0xDEADBEEF @0x10 accepted at T, then read @0x10 -> write resp_valid at T+3 with err=0; read resp_valid at T+7 with resp_rdata=0xDEADBEEF.
- Request held during WAIT/DONE with changed addr -> only the originally latched address is used; the new request is accepted at T+4.
- req_rd=req_wr=1 @0x20 -> resp_err=1, resp_rdata=0; a later read @0x20 returns the prior contents unchanged.
- DEPTH=256, read @0x401 -> with MEM_ADDR_CHECK_EN: resp_err=1, resp_rdata=0; without it: returns mem[0], err=0.
- Write 0x1234 @0x8, assert rst in cycle T+1 (WAIT) -> no resp_valid; a later read @0x8 returns 0.
